// File: rtl/RAM_shared_pkg.sv
// Shared definitions for the RAM access path: word width, RAM command opcodes
// and the arbiter FSM state encoding.
package RAM_shared_pkg;

  localparam int ADDR_SIZE = 8;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by pointer.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one command-style RAM port between two requesters, sequencing each
// access as an address word, a data word and (for reads) a bounded wait.
module ram_access_arbiter #(
  parameter int ADDR_SIZE  = RAM_shared_pkg::ADDR_SIZE,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 ack0,
  output logic [ADDR_SIZE-1:0] rdata0,
  output logic                 err0,
  output logic                 ack1,
  output logic [ADDR_SIZE-1:0] rdata1,
  output logic                 err1,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  import RAM_shared_pkg::*;

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  state_t               state;
  state_t               next_state;
  logic                 pointer;
  logic [1:0]           grant;
  logic                 gnt_idx;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 timed_out;

  rr_arbiter2 u_rr (
    .req     ({req1, req0}),
    .pointer (pointer),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timed_out  = 1'b0;
    case (state)
      IDLE:    if (|grant) next_state = ADDR;
      ADDR:    next_state = DATA;
      DATA:    next_state = we_q ? DONE : WAIT_RD;
      WAIT_RD: begin
        // Data arriving on the last allowed cycle still counts as a good read.
        if (ram_tx_valid) begin
          next_state = DONE;
        end else if (tmo_cnt >= TMO_LAST) begin
          next_state = DONE;
          timed_out  = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_rx_valid = 1'b0;
    ram_din      = '0;
    case (state)
      ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(we_q ? WR_ADDR : RD_ADDR), addr_q};
      end
      DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = we_q ? {WR_DATA, wdata_q} : {RD_DATA, {ADDR_SIZE{1'b0}}};
      end
      default: begin
        ram_rx_valid = 1'b0;
        ram_din      = '0;
      end
    endcase
    busy = (state != IDLE);
    ack0 = (state == DONE) && !gnt_idx;
    ack1 = (state == DONE) && gnt_idx;
  end

  // Transaction latch, timeout counter, round-robin pointer and per-requester results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer <= 1'b0;
      gnt_idx <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_cnt <= '0;
      rdata0  <= '0;
      err0    <= 1'b0;
      rdata1  <= '0;
      err1    <= 1'b0;
    end else begin
      if (state == IDLE && |grant) begin
        gnt_idx <= grant[1];
        we_q    <= grant[1] ? we1    : we0;
        addr_q  <= grant[1] ? addr1  : addr0;
        wdata_q <= grant[1] ? wdata1 : wdata0;
      end

      if (state != WAIT_RD) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (state == DONE) begin
        pointer <= ~gnt_idx;
      end

      if (state != DONE && next_state == DONE) begin
        if (!gnt_idx) begin
          err0 <= timed_out;
          if (state == WAIT_RD && !timed_out) rdata0 <= ram_dout;
        end else begin
          err1 <= timed_out;
          if (state == WAIT_RD && !timed_out) rdata1 <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a vector table of single transactions
// plus hand-written contention, input-change and mid-read reset sequences.
module tb_ram_access_arbiter;

  localparam int AW  = 8;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, wdata0, addr1, wdata1;
  logic          ack0, err0, ack1, err1;
  logic [AW-1:0] rdata0, rdata1;
  logic [AW+1:0] ram_din;
  logic          ram_rx_valid;
  logic [AW-1:0] ram_dout;
  logic          ram_tx_valid;
  logic          busy;

  int test_count = 0;
  int fail_count = 0;

  logic [AW-1:0] last_rdata [2];
  logic          last_err   [2];

  typedef struct {
    logic          side;
    logic          we;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
    int            delay;
    logic [AW-1:0] resp;
    logic [AW+1:0] din_a;
    logic [AW+1:0] din_d;
    int            exp_wait;
    logic [AW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [9];

  ram_access_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .rdata0       (rdata0),
    .err0         (err0),
    .ack1         (ack1),
    .rdata1       (rdata1),
    .err1         (err1),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    last_err[0]   = 1'b0;
    last_err[1]   = 1'b0;
  endtask

  // One complete transaction from IDLE back to IDLE; stray ram_tx_valid in ADDR must be ignored.
  task automatic applyStimulus(input vec_t v);
    int cycles;
    if (v.side) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    ram_tx_valid = 1'b1;
    ram_dout     = 8'hEE;
    checkOutput("addr_word", {ack1, ack0, busy, ram_rx_valid, ram_din}, {4'b0011, v.din_a});
    tick();
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    checkOutput("data_word", {ack1, ack0, ram_rx_valid, ram_din}, {3'b001, v.din_d});
    cycles = 0;
    while (!(ack0 || ack1) && cycles < 40) begin
      if (!v.we && cycles == 1) checkOutput("wait_rx_valid", {busy, ram_rx_valid}, 2'b10);
      if (!v.we && cycles == v.delay + 1) begin
        ram_tx_valid = 1'b1;
        ram_dout     = v.resp;
      end
      tick();
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
      cycles++;
    end
    checkOutput("ack_latency", cycles, 1 + v.exp_wait);
    checkOutput("ack_side", {ack1, ack0}, v.side ? 2'b10 : 2'b01);
    last_rdata[v.side] = v.exp_rdata;
    last_err[v.side]   = v.exp_err;
    checkOutput("rdata0", rdata0, last_rdata[0]);
    checkOutput("rdata1", rdata1, last_rdata[1]);
    checkOutput("err0", err0, last_err[0]);
    checkOutput("err1", err1, last_err[1]);
    tick();
    checkOutput("ack_pulse", {busy, ack1, ack0}, 3'b000);
  endtask

  initial begin : main
    int n;
    int cycles;
    logic got  [4];
    int   when [4];
    logic ack_seen;

    // side we addr wdata delay resp din_a din_d wait rdata err
    vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, -1, 8'h00, 10'h03C, 10'h1A5, 0,  8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 0,  8'hA5, 10'h23C, 10'h300, 1,  8'hA5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h55, 8'h00, 99, 8'h12, 10'h255, 10'h300, 15, 8'hA5, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 4,  8'h5A, 10'h210, 10'h300, 5,  8'h5A, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 14, 8'h77, 10'h2FF, 10'h300, 15, 8'h77, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hFF, -1, 8'h00, 10'h000, 10'h1FF, 0,  8'h77, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h01, 8'h00, 99, 8'h00, 10'h201, 10'h300, 15, 8'h77, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h02, 8'h00, 2,  8'h33, 10'h202, 10'h300, 3,  8'h33, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'hC3, 8'h5A, -1, 8'h00, 10'h0C3, 10'h15A, 0,  8'h5A, 1'b0};

    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    ram_dout = '0; ram_tx_valid = 1'b0;
    resetModel();
    #2;
    checkOutput("reset_outputs",
                {ack0, ack1, err0, err1, busy, ram_rx_valid, ram_din, rdata0, rdata1}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Late changes to addr/wdata/we and a request pulse outside IDLE must not leak in.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h66;
    tick();
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h99; wdata0 = 8'h11;
    req1 = 1'b1;
    checkOutput("latched_addr", ram_din, 10'h040);
    tick();
    req1 = 1'b0; addr0 = 8'hBB;
    checkOutput("latched_data", ram_din, 10'h166);
    tick();
    checkOutput("latched_ack", {ack1, ack0}, 2'b01);
    tick();
    checkOutput("ignored_req_idle", busy, 1'b0);
    tick();
    checkOutput("ignored_req_still_idle", busy, 1'b0);

    // Simultaneous requests from reset: requester 0 first, then strict alternation.
    rst_n = 1'b0;
    resetModel();
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h11; wdata0 = 8'hAA;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h22; wdata1 = 8'hBB;
    n = 0;
    cycles = 0;
    while (n < 4 && cycles < 40) begin
      tick();
      cycles++;
      if (ack0 || ack1) begin
        got[n]  = ack1;
        when[n] = cycles;
        n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("contention_acks", n, 4);
    if (n > 0) checkOutput("contention_first_latency", when[0], 3);
    for (int i = 0; i < n; i++) begin
      checkOutput("grant_order", got[i], i % 2);
      if (i > 0) checkOutput("grant_spacing", when[i] - when[i-1], 4);
    end
    tick();
    tick();

    // Asynchronous reset while waiting for read data.
    applyStimulus(vecs[1]);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h44;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("mid_read_busy", {busy, ram_rx_valid}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("mid_read_reset",
                {ack0, ack1, err0, err1, busy, ram_rx_valid, ram_din, rdata0, rdata1}, 32'h0);
    tick();
    rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ack_seen = ack_seen | ack0 | ack1 | busy;
    end
    checkOutput("no_ack_after_abort", ack_seen, 1'b0);
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
